// File: rtl/ocp2axil_bridge_if.sv
// Bundles the OCP slave-side and AXI4-Lite master-side signals of the bridge.
// slave modport is the bridge's view; master modport is the surrounding environment.
// Flow control is carried entirely by the OCP accept/response and AXI valid/ready pairs.
`timescale 1ns/1ps
interface ocp2axil_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [2:0]          MCmd;
    logic [ADDR_W-1:0]   MAddr;
    logic [DATA_W-1:0]   MData;
    logic [DATA_W/8-1:0] MByteEn;
    logic                SCmdAccept;
    logic [1:0]          SResp;
    logic [DATA_W-1:0]   SData;
    logic                MRespAccept;

    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  MCmd, MAddr, MData, MByteEn, MRespAccept,
        output SCmdAccept, SResp, SData,
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport master (
        output MCmd, MAddr, MData, MByteEn, MRespAccept,
        input  SCmdAccept, SResp, SData,
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/ocp2axil_bridge.sv
// Single-outstanding OCP simple read/write to AXI4-Lite bridge.
// Latency: accept-to-SResp 3 cycles minimum (1 cycle for unsupported commands).
// Backpressure: SCmdAccept only in IDLE; AXI stalls and MRespAccept hold the bridge indefinitely.
`timescale 1ns/1ps
module ocp2axil_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    ocp2axil_bridge_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, OCP_RESP
    } state_e;

    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_DVA  = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b11;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   sdata_q, sdata_d;
    logic [1:0]          resp_q, resp_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;

    // OKAY/EXOKAY complete normally; SLVERR/DECERR become an OCP error.
    function automatic logic [1:0] map_resp(input logic [1:0] axi_resp);
        return (axi_resp == 2'b00 || axi_resp == 2'b01) ? RESP_DVA : RESP_ERR;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            sdata_q   <= '0;
            resp_q    <= RESP_NULL;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            sdata_q   <= sdata_d;
            resp_q    <= resp_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        sdata_d   = sdata_q;
        resp_d    = resp_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        unique case (state_q)
            IDLE: begin
                if (bus.MCmd != 3'd0) begin
                    addr_d  = bus.MAddr;
                    wdata_d = bus.MData;
                    wstrb_d = bus.MByteEn;
                    sdata_d = '0;
                    if (bus.MCmd == 3'd1) begin
                        state_d = WR_REQ;
                    end else if (bus.MCmd == 3'd2) begin
                        state_d = RD_REQ;
                    end else begin
                        resp_d  = RESP_ERR;
                        state_d = OCP_RESP;
                    end
                end
            end
            WR_REQ: begin
                // AW and W may complete in either order or together.
                aw_done_d = aw_done_q | bus.awready;
                w_done_d  = w_done_q  | bus.wready;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bus.bvalid) begin
                    resp_d  = map_resp(bus.bresp);
                    state_d = OCP_RESP;
                end
            end
            RD_REQ: begin
                if (bus.arready) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (bus.rvalid) begin
                    sdata_d = bus.rdata;
                    resp_d  = map_resp(bus.rresp);
                    state_d = OCP_RESP;
                end
            end
            OCP_RESP: begin
                if (bus.MRespAccept) begin
                    resp_d  = RESP_NULL;
                    sdata_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.SCmdAccept = (state_q == IDLE) && (bus.MCmd != 3'd0);
    assign bus.SResp      = (state_q == OCP_RESP) ? resp_q  : RESP_NULL;
    assign bus.SData      = (state_q == OCP_RESP) ? sdata_q : '0;

    assign bus.awaddr  = addr_q;
    assign bus.awprot  = 3'b000;
    assign bus.awvalid = (state_q == WR_REQ) && !aw_done_q;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = wstrb_q;
    assign bus.wvalid  = (state_q == WR_REQ) && !w_done_q;
    assign bus.bready  = (state_q == WR_RESP);
    assign bus.araddr  = addr_q;
    assign bus.arprot  = 3'b000;
    assign bus.arvalid = (state_q == RD_REQ);
    assign bus.rready  = (state_q == RD_RESP);
endmodule
